// File: rtl/add_subtract_pkg.sv
// Shared constants for the add_subtract block: default operand width and the
// operation-select encoding.
package add_subtract_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : add_subtract_pkg

// File: rtl/add_subtract_full_adder.sv
// One-bit full adder cell; the add_subtract datapath is a ripple chain of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/add_subtract.sv
// Registered ripple-carry adder/subtractor with carry-out and signed-overflow
// flags; one cycle of latency, a new operand pair accepted every cycle.
module add_subtract
    import add_subtract_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             add_sub,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             o_ovf
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the chain's carry-in.
    assign sub      = (add_sub == OP_SUB);
    assign b_eff    = b_i ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a_i[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    // NOTE: reset is sampled on the clock edge only, and all state uses
    // non-blocking assignments so the three outputs always come from one edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_o <= '0;
            cout_o   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            result_o <= sum;
            cout_o   <= carry[WIDTH];
            o_ovf    <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

endmodule : add_subtract

// File: tb/tb_add_subtract.sv
// Self-checking bench for add_subtract (WIDTH = 8): directed vectors with
// hand-computed results, reset cases, then back-to-back random operands.
module tb_add_subtract;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add_sub;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    add_subtract #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .a_i      (a),
        .b_i      (b),
        .add_sub  (add_sub),
        .result_o (result),
        .cout_o   (cout),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operand pair, let one edge sample it, then compare all outputs.
    task automatic vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic op, input logic [7:0] er, input logic ec, input logic eo);
        a       = va;
        b       = vb;
        add_sub = op;
        @(posedge clk);
        #1;
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".cout"},   32'(cout),   32'(ec));
        check({tag, ".ovf"},    32'(ovf),    32'(eo));
    endtask

    initial begin
        logic [8:0] wide;
        logic [7:0] be;
        logic       exp_ovf;

        rst_n = 1'b0;
        @(negedge clk);
        vec("reset_hold", 8'h55, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        vec("reset_hold2", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        vec("add_5_3",     8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 1'b0);
        vec("hold_5_3",    8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 1'b0);
        vec("add_70_70",   8'd70,  8'd70,  1'b0, 8'h8C,  1'b0, 1'b1);
        vec("add_186_186", 8'd186, 8'd186, 1'b0, 8'h74,  1'b1, 1'b1);
        vec("sub_8_3",     8'd8,   8'd3,   1'b1, 8'd5,   1'b1, 1'b0);
        vec("sub_5_10",    8'd5,   8'd10,  1'b1, 8'hFB,  1'b0, 1'b0);
        vec("sub_70_186",  8'd70,  8'd186, 1'b1, 8'h8C,  1'b0, 1'b1);
        vec("sub_0_0",     8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0);
        vec("sub_min_1",   8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1);
        vec("add_ff_1",    8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0);
        vec("add_7f_1",    8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1);

        // Reset asserted mid-stream wins over live operands, then recovery
        // produces the next result after one edge.
        rst_n = 1'b0;
        vec("reset_mid", 8'd100, 8'd27, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        vec("after_reset", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);

        // Back-to-back random operands, operation toggling every cycle.
        for (int i = 0; i < 10000; i++) begin
            a       = 8'($urandom);
            b       = 8'($urandom);
            add_sub = 1'(i & 1);
            be      = add_sub ? ~b : b;
            wide    = {1'b0, a} + {1'b0, be} + {8'd0, add_sub};
            exp_ovf = (a[7] == be[7]) && (wide[7] != a[7]);
            @(posedge clk);
            #1;
            check("rand.result", 32'(result), 32'(wide[7:0]));
            check("rand.cout",   32'(cout),   32'(wide[8]));
            check("rand.ovf",    32'(ovf),    32'(exp_ovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_add_subtract

// File: doc/add_subtract.md
ADD_SUBTRACT -- requirements
Module: add_subtract

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 a_i  input  WIDTH  operand A, unsigned or two's-complement.
REQ-005 b_i  input  WIDTH  operand B, unsigned or two's-complement.
REQ-006 add_sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 result_o  output  WIDTH  registered sum or difference, modulo 2^WIDTH.
REQ-008 cout_o  output  1  registered carry-out of the MSB.
REQ-009 o_ovf  output  1  registered two's-complement signed-overflow flag.

Function
REQ-010 Datapath SHALL compute S = A + (B XOR {WIDTH{add_sub}}) + add_sub, i.e. A+B or A+~B+1.
REQ-011 result_o SHALL be S[WIDTH-1:0]; cout_o SHALL be the carry out of bit WIDTH-1.
REQ-012 Subtraction: cout_o = 1 means no borrow (A >= B unsigned); cout_o = 0 means borrow.
REQ-013 o_ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, equivalently 1 exactly when the operands fed to the adder share a sign and the result sign differs.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at rising edge N appear on all three outputs after edge N.
REQ-015 Block SHALL have no handshake; it accepts new operands every cycle, with throughput 1 per cycle.
REQ-016 All three outputs SHALL update together from the same sampled inputs, never mixing cycles.
REQ-017 Changing add_sub between cycles SHALL take effect on the next sampled result, with no extra latency.
REQ-018 Boundary cases: 0-0 gives 0 with cout 1, ovf 0; MIN-1 (0x80-0x01) gives 0x7F with ovf 1; 0xFF+0x01 gives 0x00 with cout 1, ovf 0.
REQ-019 Outputs SHALL hold their value while inputs are stable; there are no internal states beyond the output registers.

Reset
REQ-020 While rst_ni = 0 at a rising edge, result_o, cout_o and o_ovf SHALL all be cleared to 0.
REQ-021 Reset SHALL override the sampled inputs in that cycle, including reset asserted mid-stream.
REQ-022 The first valid result after reset deassertion SHALL appear one cycle after the first sampling edge with rst_ni = 1.
REQ-023 No asynchronous reset path SHALL exist.

Structure
REQ-024 Shared package add_subtract_pkg SHALL hold the WIDTH default constant and the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
REQ-025 Adder SHALL be a ripple-carry chain of WIDTH instances of one sub-module, full_adder, with ports a, b, cin, sum, cout.
REQ-026 The carry into the MSB SHALL be taken from the chain for overflow generation.
REQ-027 The output register SHALL be a single always_ff stage in add_subtract.
REQ-028 The top level SHALL use no behavioural "+" operator; arithmetic comes only from full_adder.

Verification (WIDTH = 8, each check 1 cycle after the input is applied)
REQ-029 Reset: hold rst_ni = 0 with a = 0x55, b = 0x22 -> result 0x00, cout 0, ovf 0.
REQ-030 Add: 5+3 -> result 8, cout 0, ovf 0.
REQ-031 Add overflow: 70+70 -> result 140 (0x8C), cout 0, ovf 1; 186+186 -> result 116 (0x74), cout 1, ovf 1.
REQ-032 Subtract: 8-3 -> result 5, cout 1, ovf 0; 5-10 -> result 251 (0xFB), cout 0, ovf 0.
REQ-033 Subtract overflow: 70-186 -> result 140 (0x8C), cout 0, ovf 1.
REQ-034 Back-to-back random operands and add_sub toggling every cycle, checked against a reference model with a 1-cycle delay -> zero mismatches over 10k cycles.
